// File: rtl/ahb_dma_ch_arb.sv
// Channel arbiter and transfer sequencer for the AHB DMA: priority plus round-robin
// channel selection, start/done handshake with the engine, and the global pause protocol.
module ahb_dma_ch_arb #(
   parameter int unsigned CH_NUM   = 4,
   parameter int unsigned CH_BITS  = $clog2(CH_NUM),
   parameter int unsigned PRI_BITS = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CH_NUM-1:0]          ch_req,
   input  logic [CH_NUM*PRI_BITS-1:0] ch_pri,
   input  logic                       pause_req,
   input  logic                       dma_busy,
   input  logic                       dma_done,
   input  logic                       dma_err,
   output logic [CH_BITS-1:0]         ch_sel,
   output logic                       dma_start,
   output logic                       paused,
   output logic                       arb_busy,
   output logic [CH_NUM-1:0]          ch_done,
   output logic [CH_NUM-1:0]          ch_err
);

   typedef enum logic [2:0] {StIdle, StArb, StGrant, StRun, StPaused} state_e;

   state_e              state_q, state_d;
   logic [CH_BITS-1:0]  ch_sel_q, ch_sel_d;
   logic [CH_BITS-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CH_NUM-1:0]   ch_done_q, ch_done_d;
   logic [CH_NUM-1:0]   ch_err_q, ch_err_d;
   logic [CH_BITS-1:0]  winner;
   logic [PRI_BITS-1:0] best_pri;
   logic                found;

   // Scan starts just after the last granted channel; strict '>' keeps the first tied channel.
   always_comb begin : arbitrate
      int unsigned idx;
      idx      = 0;
      winner   = '0;
      best_pri = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         idx = 32'(rr_ptr_q) + 32'd1 + i;
         if (idx >= CH_NUM) idx = idx - CH_NUM;
         if (ch_req[idx] && (!found || (ch_pri[idx*PRI_BITS +: PRI_BITS] > best_pri))) begin
            found    = 1'b1;
            best_pri = ch_pri[idx*PRI_BITS +: PRI_BITS];
            winner   = CH_BITS'(idx);
         end
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      ch_sel_d  = ch_sel_q;
      rr_ptr_d  = rr_ptr_q;
      ch_done_d = '0;
      ch_err_d  = '0;
      unique case (state_q)
         StIdle: begin
            if (pause_req)   state_d = StPaused;
            else if (|ch_req) state_d = StArb;
         end
         StArb: begin
            if (|ch_req) begin
               ch_sel_d = winner;
               state_d  = StGrant;
            end else begin
               state_d  = StIdle;
            end
         end
         StGrant, StRun: begin
            // A completion seen in GRANT is a zero-length transfer; error beats done.
            if (dma_err || dma_done) begin
               if (dma_err) ch_err_d  = CH_NUM'(1) << ch_sel_q;
               else         ch_done_d = CH_NUM'(1) << ch_sel_q;
               rr_ptr_d = ch_sel_q;
               state_d  = StIdle;
            end else if ((state_q == StGrant) && dma_busy) begin
               state_d  = StRun;
            end
         end
         StPaused: begin
            if (!pause_req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         ch_sel_q  <= '0;
         rr_ptr_q  <= CH_BITS'(CH_NUM - 1);
         ch_done_q <= '0;
         ch_err_q  <= '0;
      end else begin
         state_q   <= state_d;
         ch_sel_q  <= ch_sel_d;
         rr_ptr_q  <= rr_ptr_d;
         ch_done_q <= ch_done_d;
         ch_err_q  <= ch_err_d;
      end
   end

   assign ch_sel    = ch_sel_q;
   assign dma_start = (state_q == StGrant);
   assign paused    = (state_q == StPaused);
   assign arb_busy  = (state_q == StArb) || (state_q == StGrant) || (state_q == StRun);
   assign ch_done   = ch_done_q;
   assign ch_err    = ch_err_q;

endmodule

// File: doc/ahb_dma_ch_arb.md
# ahb_dma_ch_arb

Channel arbiter and transfer sequencer for the AHB DMA. It examines per-channel request/enable lines and priorities from the channel register files and selects one channel. It drives `ch_sel` into the register file and DMA engine, then issues a start handshake and holds the selection until the engine reports done or error. It also implements the global pause protocol: `pause_req` from the DMA CSR and `paused` back to it.

## Interface
Parameters:
- `CH_NUM`, 4: number of channels, legal range 2..31.
- `CH_BITS`, `$clog2(CH_NUM)`: width of `ch_sel`.
- `PRI_BITS`, 3: priority field width per channel.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `ch_req` in CH_NUM: per-channel "enabled and request pending" level.
- `ch_pri` in CH_NUM*PRI_BITS: packed priorities; channel k occupies `[k*PRI_BITS +: PRI_BITS]`; larger value wins.
- `pause_req` in 1: global pause request (CSR bit 0).
- `dma_busy` in 1: engine accepted start and is transferring.
- `dma_done` in 1: one-cycle pulse; current transfer finished.
- `dma_err` in 1: one-cycle pulse; current transfer aborted on bus error.
- `ch_sel` out CH_BITS: registered selected channel.
- `dma_start` out 1: start request to engine; level.
- `paused` out 1: arbiter idle and held by pause.
- `arb_busy` out 1: high in every state except IDLE and PAUSED.
- `ch_done` out CH_NUM: one-hot, one-cycle completion pulse.
- `ch_err` out CH_NUM: one-hot, one-cycle error pulse.

## Operation
- States: IDLE, ARB, GRANT, RUN, PAUSED. Reset enters IDLE. All outputs are 0 at reset. `rr_ptr` (last granted channel) resets to CH_NUM-1.
- **IDLE:**
  - If `pause_req`, go to PAUSED.
  - Else if `|ch_req`, go to ARB.
  - Otherwise stay in IDLE.
- **ARB (one cycle):**
  - The winner is the requesting channel with the highest `ch_pri`.
  - Ties are broken round-robin: scan from `rr_ptr+1`, wrapping modulo CH_NUM, and take the first tied channel.
  - At the clock edge: `ch_sel` <= winner, `dma_start` <= 1, go to GRANT.
  - If `ch_req` has dropped to all-zero in ARB, return to IDLE with no grant.
- **GRANT:**
  - Hold `dma_start`=1 and `ch_sel` stable.
  - `dma_busy`=1: `dma_start` <= 0, go to RUN.
  - `dma_done` or `dma_err` already in GRANT (zero-length transfer): complete exactly as in RUN.
- **RUN:**
  - Hold `ch_sel` until completion.
  - Completion: pulse `ch_done[ch_sel]` or `ch_err[ch_sel]` for one cycle, set `rr_ptr` <= `ch_sel`, clear `dma_start`, go to IDLE.
- **PAUSED:**
  - `paused`=1 for as long as the state holds.
  - When `pause_req`=0, go to IDLE; `paused` falls the same edge.
- Pause is non-preemptive. `pause_req` rising in ARB, GRANT or RUN does not abort the transfer. The arbiter finishes it, and IDLE then enters PAUSED on the following edge without arbitrating.
- Requests are sampled only in IDLE and ARB. Changes to `ch_req` or `ch_pri` after ARB do not alter the current grant.

## Timing
- `ch_req` first sampled high at edge N (IDLE): ARB during N..N+1. `ch_sel` valid and `dma_start`=1 from edge N+1.
- `dma_start` is held until the edge on which `dma_busy` is sampled high. There is no timeout.
- A `dma_done` or `dma_err` pulse sampled at edge M:
  - `ch_done`/`ch_err` is high during M..M+1.
  - The state is IDLE after M.
  - The earliest next `dma_start` is edge M+2.
- `dma_done` and `dma_err` in the same cycle: error wins. Only `ch_err` pulses.
- `dma_done`/`dma_err` outside GRANT/RUN are ignored.
- Back-to-back grants therefore cost 2 idle cycles: IDLE and ARB.
- `rst` low at any time forces IDLE asynchronously:
  - `dma_start`, `ch_sel`, `paused`, `arb_busy`, `ch_done`, `ch_err` go to 0.
  - `rr_ptr` goes to CH_NUM-1.
- Priority compare is unsigned and PRI_BITS wide. The round-robin index wraps from CH_NUM-1 to 0.

## Test plan
- **Single request:** CH_NUM=4, `ch_req`=4'b0100 at edge 0.
  - Expect `ch_sel`=2 and `dma_start`=1 from edge 1.
  - Drive `dma_busy`=1 at edge 3: `dma_start`=0 at edge 3.
  - Drive `dma_done` at edge 6: `ch_done`=4'b0100 for one cycle.
- **Priority:** `ch_req`=4'b1111, `ch_pri`={3,1,5,5} for channels 3..0.
  - Grants go to channel 0, then channel 1 (tie rotation).
  - Channel 3 is granted only after channels 0 and 1 drop their requests.
- **Round-robin wrap:** all four channels requesting at equal priority.
  - The first four grants are 0,1,2,3.
  - The fifth grant is 0.
- **Pause:** assert `pause_req` mid-RUN on channel 1.
  - The transfer completes and `ch_done[1]` pulses.
  - `paused`=1 the next cycle and no `dma_start` is issued while `ch_req`≠0.
  - Drop `pause_req`: `paused`=0 and arbitration resumes.
- **Error and simultaneity:** pulse `dma_done` and `dma_err` together in RUN on channel 3.
  - Expect `ch_err`=4'b1000 and `ch_done`=0.
  - Return to IDLE.
- **Reset mid-GRANT:** pull `rst` low while `dma_start`=1.
  - All outputs go to 0 immediately.
  - After release, a tie among all channels grants channel 0.
